uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Command-layer controller behind the 9600-baud UART byte receiver (100 MHz `clk`).
- Detects each completed byte from the receiver's level-type `over` flag.
- Assembles 4-byte voice-module frames, validates them, and applies them to the purifier configuration registers (power, fan speed, mode, off-timer).
- Reports accepted commands and frame errors as single-cycle pulses for downstream control and status logic.

Parameters:
- TIMEOUT_CYC, 312500, max clk cycles allowed between consecutive bytes of one frame (≈3 byte-times at 9600 baud); benches override to a small value, e.g. 200.
- HDR_BYTE, 8'hAA, frame header value.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  receiver data byte; stable whenever rx_over rises
- rx_over  in  1  receiver byte-complete flag (level); each rising edge = one new byte
- power_on  out  1  purifier power state
- fan_speed  out  2  fan level 0..3
- mode  out  2  0=auto, 1=manual, 2=sleep (3 never written)
- timer_min  out  8  off-timer in minutes, 0=disabled
- cmd_valid  out  1  one-cycle pulse: frame accepted and applied
- cmd_code  out  8  code of last accepted command
- frame_err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  reason for last reject: 0=timeout, 1=checksum, 2=unknown cmd, 3=bad arg

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, timeout counter 0.
- Edge detect register `over_q` resets to 1, so an rx_over already high at reset release is not counted as a byte.
- Byte strobe: `byte_stb = rx_over & ~over_q`. rx_byte is sampled in that same cycle.
- Frame format: HDR, CMD, ARG, CHK, where CHK = (CMD + ARG) mod 256.

FSM states:
- IDLE:
  - On byte_stb with HDR_BYTE -> GET_CMD.
  - Any other byte is discarded silently; no error is raised.
- GET_CMD -> GET_ARG -> GET_CHK, advancing one state per byte_stb and capturing each byte.
  - A byte equal to HDR_BYTE in these states is treated as data; there is no resync.
- GET_CHK: on byte_stb -> CHECK.
- CHECK (1 cycle): evaluate in priority order checksum, then cmd code, then arg range; then -> IDLE.
- Timeout: the counter clears on every byte_stb and increments in GET_CMD, GET_ARG and GET_CHK.
  - Reaching TIMEOUT_CYC-1 with no byte -> IDLE, frame_err=1, err_code=0.
  - If byte_stb and timeout coincide, the byte wins and the counter clears.

Commands (applied in the cycle after CHECK; cmd_valid pulses in that same cycle; cmd_code updated):
- 0x01 power: ARG 0/1 -> power_on. Power-off also clears fan_speed and timer_min to 0.
- 0x02 fan: ARG 0..3 -> fan_speed. If power_on=0, forces power_on=1.
- 0x03 mode: ARG 0..2 -> mode. Sleep (2) also forces fan_speed=1.
- 0x04 timer: any ARG -> timer_min.
- Other CMD -> err 2. Out-of-range ARG -> err 3. Bad CHK -> err 1.
- On any error, configuration outputs are unchanged and cmd_code is unchanged.

Timing and boundary conditions:
- Latency: the final CHK strobe -> cmd_valid/frame_err is exactly 2 cycles later.
- cmd_valid and frame_err are never high together.
- byte_stb arriving during CHECK or the apply cycle is evaluated in IDLE rules on its own cycle; it is not lost. The state logic accepts a header in any cycle where the FSM returns to IDLE.
- rst mid-frame: immediate return to IDLE and all outputs cleared (configuration included); no error pulse.

Decomposition:
- Shared package `purifier_pkg` holds:
  - HDR_BYTE default
  - command codes CMD_POWER / CMD_FAN / CMD_MODE / CMD_TIMER
  - mode encodings MODE_AUTO / MODE_MANUAL / MODE_SLEEP
  - error codes ERR_TIMEOUT / ERR_CHK / ERR_CMD / ERR_ARG
  - FSM state encoding
- One natural sub-module, `uart_frame_rx`: edge detect, timeout counter, and framing FSM, outputting {cmd, arg, frame_done, chk_ok, timeout}.
- The top level holds command decode and the configuration registers.

Test Plan:
- Reset with rx_over held high, then release -> no byte counted; all outputs 0. Next frame AA 01 01 02 -> power_on=1, cmd_valid pulse, cmd_code=01.
- Bytes 55 AA 02 03 05 -> leading 55 ignored; fan_speed=3, power_on=1, exactly one cmd_valid, no frame_err.
- AA 02 02 05 (checksum should be 04) -> frame_err, err_code=1, fan_speed unchanged. Then AA 07 00 07 -> err_code=2. Then AA 03 03 06 -> err_code=3.
- TIMEOUT_CYC=200: AA 04, then a 250-cycle gap -> frame_err with err_code=0 exactly 199 cycles after the 04 strobe. Then AA 04 1E 22 -> timer_min=30.
- Power on and fan 2, then AA 03 02 05 -> mode=2, fan_speed=1. Then AA 01 00 01 -> power_on=0, fan_speed=0, timer_min=0, mode stays 2.
- rst asserted after AA 02 received, then 01 03 sent -> no command applied, no error pulse; outputs remain 0.

Source files
------------

// File: rtl/purifier_pkg.sv
// Shared definitions for the purifier UART command path.
// Holds the default frame header, the voice-module command codes, the mode
// and error encodings reported on the outputs, and the framing FSM states.
package purifier_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;

    // Command codes carried in the CMD byte of a frame
    localparam logic [7:0] CMD_POWER = 8'h01;
    localparam logic [7:0] CMD_FAN   = 8'h02;
    localparam logic [7:0] CMD_MODE  = 8'h03;
    localparam logic [7:0] CMD_TIMER = 8'h04;

    // Operating mode encodings (3 is never written)
    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_SLEEP  = 2'd2;

    // Reject reasons reported on err_code
    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_CMD     = 2'd2;
    localparam logic [1:0] ERR_ARG     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ARG,
        ST_GET_CHK,
        ST_CHECK
    } frame_state_t;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Bundle between the UART byte receiver / purifier control logic and the
// command sequencer.
//   rx_byte, rx_over          : receiver byte and level byte-complete flag
//   power_on .. timer_min     : purifier configuration registers
//   cmd_valid, cmd_code       : accepted-command pulse and last accepted code
//   frame_err, err_code       : rejected-frame pulse and last reject reason
// master = receiver/control side, slave = sequencer.
interface uart_cmd_sequencer_if;
    logic [7:0] rx_byte;
    logic       rx_over;
    logic       power_on;
    logic [1:0] fan_speed;
    logic [1:0] mode;
    logic [7:0] timer_min;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       frame_err;
    logic [1:0] err_code;

    modport master (
        output rx_byte, rx_over,
        input  power_on, fan_speed, mode, timer_min,
        input  cmd_valid, cmd_code, frame_err, err_code
    );

    modport slave (
        input  rx_byte, rx_over,
        output power_on, fan_speed, mode, timer_min,
        output cmd_valid, cmd_code, frame_err, err_code
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame assembler for 4-byte voice-module frames: HDR, CMD, ARG, CHK.
// Turns the receiver's level flag into a byte strobe, collects CMD/ARG,
// checks CHK = CMD + ARG (mod 256) and enforces an inter-byte timeout.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rx_byte       : receiver byte, valid when rx_over rises
//   rx_over       : receiver byte-complete level flag
//   cmd, arg      : captured command and argument bytes
//   frame_done    : one cycle high while the FSM sits in CHECK
//   chk_ok        : checksum result, valid with frame_done
//   timeout       : one-cycle pulse when a partial frame is abandoned
module uart_frame_rx
    import purifier_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 312500,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_over,
    output logic [7:0] cmd,
    output logic [7:0] arg,
    output logic       frame_done,
    output logic       chk_ok,
    output logic       timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    // The counter reads 0 in the cycle after a strobe, and the timeout
    // then passes through this module's pulse register and the top's
    // frame_err register; firing at TIMEOUT_CYC-4 makes frame_err appear
    // exactly TIMEOUT_CYC-1 cycles after the last byte strobe.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 4);

    frame_state_t     state_reg;
    logic             over_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       cmd_reg;
    logic [7:0]       arg_reg;
    logic             frame_done_reg;
    logic             chk_ok_reg;
    logic             timeout_reg;

    logic       byte_stb;
    logic       waiting;
    logic       tmo_hit;
    logic [7:0] chk_sum;

    assign byte_stb = rx_over & ~over_q_reg;
    assign waiting  = (state_reg == ST_GET_CMD) || (state_reg == ST_GET_ARG) ||
                      (state_reg == ST_GET_CHK);
    // A byte arriving in the expiry cycle takes priority over the timeout
    assign tmo_hit  = waiting && !byte_stb && (cnt_reg == TMO_LAST);
    assign chk_sum  = cmd_reg + arg_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Starts high so a flag already up at reset release is not a byte
            over_q_reg     <= 1'b1;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            cmd_reg        <= '0;
            arg_reg        <= '0;
            frame_done_reg <= 1'b0;
            chk_ok_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            over_q_reg     <= rx_over;
            frame_done_reg <= 1'b0;
            timeout_reg    <= 1'b0;

            if (byte_stb || !waiting)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CNT_W'(1);

            case (state_reg)
                // CHECK lasts one cycle; a byte landing there follows IDLE rules
                ST_IDLE, ST_CHECK: begin
                    if (byte_stb && rx_byte == HDR_BYTE)
                        state_reg <= ST_GET_CMD;
                    else
                        state_reg <= ST_IDLE;
                end
                ST_GET_CMD: begin
                    if (byte_stb) begin
                        cmd_reg   <= rx_byte;
                        state_reg <= ST_GET_ARG;
                    end else if (tmo_hit) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_GET_ARG: begin
                    if (byte_stb) begin
                        arg_reg   <= rx_byte;
                        state_reg <= ST_GET_CHK;
                    end else if (tmo_hit) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_GET_CHK: begin
                    if (byte_stb) begin
                        chk_ok_reg     <= (chk_sum == rx_byte);
                        frame_done_reg <= 1'b1;
                        state_reg      <= ST_CHECK;
                    end else if (tmo_hit) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd        = cmd_reg;
    assign arg        = arg_reg;
    assign frame_done = frame_done_reg;
    assign chk_ok     = chk_ok_reg;
    assign timeout    = timeout_reg;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Command layer behind the UART byte receiver: validates assembled frames
// and applies them to the purifier configuration registers.
// Ports:
//   clk, rst : 100 MHz clock, synchronous active-high reset
//   bus      : slave side of uart_cmd_sequencer_if (receiver inputs,
//              configuration outputs, cmd_valid/frame_err status pulses)
module uart_cmd_sequencer
    import purifier_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 312500,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_sequencer_if.slave  bus
);

    logic [7:0] f_cmd;
    logic [7:0] f_arg;
    logic       f_done;
    logic       f_chk_ok;
    logic       f_timeout;

    uart_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .HDR_BYTE    (HDR_BYTE)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (bus.rx_byte),
        .rx_over    (bus.rx_over),
        .cmd        (f_cmd),
        .arg        (f_arg),
        .frame_done (f_done),
        .chk_ok     (f_chk_ok),
        .timeout    (f_timeout)
    );

    logic       power_on_reg;
    logic [1:0] fan_speed_reg;
    logic [1:0] mode_reg;
    logic [7:0] timer_min_reg;
    logic       cmd_valid_reg;
    logic [7:0] cmd_code_reg;
    logic       frame_err_reg;
    logic [1:0] err_code_reg;

    logic cmd_known;
    logic arg_ok;

    always_comb begin
        cmd_known = 1'b1;
        arg_ok    = 1'b0;
        case (f_cmd)
            CMD_POWER: arg_ok = (f_arg <= 8'd1);
            CMD_FAN:   arg_ok = (f_arg <= 8'd3);
            CMD_MODE:  arg_ok = (f_arg <= {6'd0, MODE_SLEEP});
            CMD_TIMER: arg_ok = 1'b1;
            default:   cmd_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            power_on_reg  <= 1'b0;
            fan_speed_reg <= 2'd0;
            mode_reg      <= MODE_AUTO;
            timer_min_reg <= 8'd0;
            cmd_valid_reg <= 1'b0;
            cmd_code_reg  <= 8'd0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_TIMEOUT;
        end else begin
            cmd_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            if (f_timeout) begin
                frame_err_reg <= 1'b1;
                err_code_reg  <= ERR_TIMEOUT;
            end else if (f_done) begin
                // Reject priority: checksum, then command code, then argument
                if (!f_chk_ok) begin
                    frame_err_reg <= 1'b1;
                    err_code_reg  <= ERR_CHK;
                end else if (!cmd_known) begin
                    frame_err_reg <= 1'b1;
                    err_code_reg  <= ERR_CMD;
                end else if (!arg_ok) begin
                    frame_err_reg <= 1'b1;
                    err_code_reg  <= ERR_ARG;
                end else begin
                    cmd_valid_reg <= 1'b1;
                    cmd_code_reg  <= f_cmd;
                    case (f_cmd)
                        CMD_POWER: begin
                            power_on_reg <= f_arg[0];
                            // Switching off also drops fan and off-timer
                            if (!f_arg[0]) begin
                                fan_speed_reg <= 2'd0;
                                timer_min_reg <= 8'd0;
                            end
                        end
                        CMD_FAN: begin
                            fan_speed_reg <= f_arg[1:0];
                            power_on_reg  <= 1'b1;
                        end
                        CMD_MODE: begin
                            mode_reg <= f_arg[1:0];
                            if (f_arg[1:0] == MODE_SLEEP)
                                fan_speed_reg <= 2'd1;
                        end
                        CMD_TIMER: timer_min_reg <= f_arg;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.power_on  = power_on_reg;
    assign bus.fan_speed = fan_speed_reg;
    assign bus.mode      = mode_reg;
    assign bus.timer_min = timer_min_reg;
    assign bus.cmd_valid = cmd_valid_reg;
    assign bus.cmd_code  = cmd_code_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.err_code  = err_code_reg;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: frames are driven byte by byte, the
// expected outcome of each frame is queued when its last byte is driven and
// compared (including arrival cycle) when cmd_valid or frame_err pulses.
module tb_uart_cmd_sequencer;
    import purifier_pkg::*;

    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_sequencer_if bus();

    uart_cmd_sequencer #(
        .TIMEOUT_CYC (TMO),
        .HDR_BYTE    (8'hAA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       is_err;
        logic [1:0] err;
        logic [7:0] code;
        logic       pwr;
        logic [1:0] fan;
        logic [1:0] mode;
        logic [7:0] tmr;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    vec_t vecs[14];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic is_err, input logic [1:0] err, input logic [7:0] code,
                                input logic pwr, input logic [1:0] fan, input logic [1:0] mode,
                                input logic [7:0] tmr);
        exp_t e;
        e.is_err = is_err;
        e.err    = err;
        e.code   = code;
        e.pwr    = pwr;
        e.fan    = fan;
        e.mode   = mode;
        e.tmr    = tmr;
        e.cyc    = 0;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] b3, input exp_t e);
        vec_t v;
        v.b0 = b0;
        v.b1 = b1;
        v.b2 = b2;
        v.b3 = b3;
        v.e  = e;
        return v;
    endfunction

    // Scoreboard monitor: one line per observed transaction
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.cmd_valid || bus.frame_err)) begin
            $display("cycle %0d: %s err=%0d code=%0h pwr=%0b fan=%0d mode=%0d tmr=%0d",
                     cyc, bus.frame_err ? "reject" : "accept", bus.err_code, bus.cmd_code,
                     bus.power_on, bus.fan_speed, bus.mode, bus.timer_min);
            check("pulse_exclusive", {31'd0, bus.cmd_valid & bus.frame_err}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check("is_err", {31'd0, bus.frame_err}, {31'd0, e.is_err});
                if (e.is_err)
                    check("err_code", {30'd0, bus.err_code}, {30'd0, e.err});
                check("cmd_code", {24'd0, bus.cmd_code}, {24'd0, e.code});
                check("power_on", {31'd0, bus.power_on}, {31'd0, e.pwr});
                check("fan_speed", {30'd0, bus.fan_speed}, {30'd0, e.fan});
                check("mode", {30'd0, bus.mode}, {30'd0, e.mode});
                check("timer_min", {24'd0, bus.timer_min}, {24'd0, e.tmr});
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one byte (rx_over high one cycle, low at least one cycle)
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_byte = b;
        bus.rx_over = 1'b1;
        @(negedge clk);
        bus.rx_over = 1'b0;
        @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input exp_t e, input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        e.cyc = cyc + 2;
        sb_q.push_back(e);
        send_byte(b3, gap);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending events expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_power_on"}, {31'd0, bus.power_on}, 32'd0);
        check({tag, "_fan_speed"}, {30'd0, bus.fan_speed}, 32'd0);
        check({tag, "_mode"}, {30'd0, bus.mode}, 32'd0);
        check({tag, "_timer_min"}, {24'd0, bus.timer_min}, 32'd0);
        check({tag, "_cmd_valid"}, {31'd0, bus.cmd_valid}, 32'd0);
        check({tag, "_cmd_code"}, {24'd0, bus.cmd_code}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
        check({tag, "_err_code"}, {30'd0, bus.err_code}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        // Starting state: power on, fan 3, auto, timer 0, last code 02
        vecs[0]  = mkv(8'hAA, 8'h02, 8'h02, 8'h05, mk(1'b1, ERR_CHK, 8'h02, 1'b1, 2'd3, 2'd0, 8'h00));
        vecs[1]  = mkv(8'hAA, 8'h07, 8'h00, 8'h07, mk(1'b1, ERR_CMD, 8'h02, 1'b1, 2'd3, 2'd0, 8'h00));
        vecs[2]  = mkv(8'hAA, 8'h03, 8'h03, 8'h06, mk(1'b1, ERR_ARG, 8'h02, 1'b1, 2'd3, 2'd0, 8'h00));
        vecs[3]  = mkv(8'hAA, 8'h07, 8'h00, 8'h09, mk(1'b1, ERR_CHK, 8'h02, 1'b1, 2'd3, 2'd0, 8'h00));
        vecs[4]  = mkv(8'hAA, 8'h02, 8'h02, 8'h04, mk(1'b0, 2'd0, 8'h02, 1'b1, 2'd2, 2'd0, 8'h00));
        vecs[5]  = mkv(8'hAA, 8'h03, 8'h02, 8'h05, mk(1'b0, 2'd0, 8'h03, 1'b1, 2'd1, 2'd2, 8'h00));
        vecs[6]  = mkv(8'hAA, 8'h04, 8'h1E, 8'h22, mk(1'b0, 2'd0, 8'h04, 1'b1, 2'd1, 2'd2, 8'd30));
        vecs[7]  = mkv(8'hAA, 8'h01, 8'h00, 8'h01, mk(1'b0, 2'd0, 8'h01, 1'b0, 2'd0, 2'd2, 8'h00));
        vecs[8]  = mkv(8'hAA, 8'h02, 8'h01, 8'h03, mk(1'b0, 2'd0, 8'h02, 1'b1, 2'd1, 2'd2, 8'h00));
        vecs[9]  = mkv(8'hAA, 8'h03, 8'h01, 8'h04, mk(1'b0, 2'd0, 8'h03, 1'b1, 2'd1, 2'd1, 8'h00));
        vecs[10] = mkv(8'hAA, 8'h01, 8'h02, 8'h03, mk(1'b1, ERR_ARG, 8'h03, 1'b1, 2'd1, 2'd1, 8'h00));
        vecs[11] = mkv(8'hAA, 8'hAA, 8'h00, 8'hAA, mk(1'b1, ERR_CMD, 8'h03, 1'b1, 2'd1, 2'd1, 8'h00));
        vecs[12] = mkv(8'hAA, 8'h04, 8'hFF, 8'h03, mk(1'b0, 2'd0, 8'h04, 1'b1, 2'd1, 2'd1, 8'hFF));
        vecs[13] = mkv(8'hAA, 8'h03, 8'h00, 8'h03, mk(1'b0, 2'd0, 8'h03, 1'b1, 2'd1, 2'd0, 8'hFF));

        // Reset with rx_over already high carrying a header byte
        rst         = 1'b1;
        bus.rx_byte = 8'hAA;
        bus.rx_over = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        bus.rx_over = 1'b0;
        repeat (2) @(negedge clk);

        send_frame(8'hAA, 8'h01, 8'h01, 8'h02, mk(1'b0, 2'd0, 8'h01, 1'b1, 2'd0, 2'd0, 8'h00), 2);
        wait_drain(50);

        // Leading junk byte is dropped silently
        send_byte(8'h55, 2);
        send_frame(8'hAA, 8'h02, 8'h03, 8'h05, mk(1'b0, 2'd0, 8'h02, 1'b1, 2'd3, 2'd0, 8'h00), 2);
        wait_drain(50);

        // Inter-byte timeout after HDR, CMD
        send_byte(8'hAA, 2);
        e = mk(1'b1, ERR_TIMEOUT, 8'h02, 1'b1, 2'd3, 2'd0, 8'h00);
        e.cyc = cyc + TMO - 1;
        sb_q.push_back(e);
        send_byte(8'h04, 250);
        wait_drain(50);

        for (int i = 0; i < 14; i++) begin
            send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].e, 1);
            wait_drain(50);
        end

        // Back-to-back frames: second header lands in the apply cycle
        send_frame(8'hAA, 8'h01, 8'h01, 8'h02, mk(1'b0, 2'd0, 8'h01, 1'b1, 2'd1, 2'd0, 8'hFF), 0);
        send_frame(8'hAA, 8'h02, 8'h00, 8'h02, mk(1'b0, 2'd0, 8'h02, 1'b1, 2'd0, 2'd0, 8'hFF), 0);
        wait_drain(50);

        // Reset in the middle of a frame; the tail bytes must be ignored
        send_byte(8'hAA, 2);
        send_byte(8'h02, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        send_byte(8'h01, 2);
        send_byte(8'h03, 2);
        repeat (20) @(negedge clk);
        check_all_zero("after_midrst");
        check("queue_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
